// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer.
// Walks a synchronous instruction ROM one instruction at a time:
// FETCH presents the PC, LOAD captures the ROM word into the IR, and
// ISSUE shows it to the control decoder for one cycle.
// The decoder's Stop parks the unit in HALT.
// The decoder's Clear runs a zero-write sweep over all of data memory
// before fetching continues.
module instr_sequencer #(
    parameter int PC_WIDTH        = 8,
    parameter int INSTR_WIDTH     = 16,
    parameter int DMEM_ADDR_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       Start,
    output logic [PC_WIDTH-1:0]        InstrAddr,
    input  logic [INSTR_WIDTH-1:0]     InstrData,
    output logic [2:0]                 OpCode,
    output logic [INSTR_WIDTH-4:0]     Fields,
    output logic                       IssueValid,
    input  logic                       Stop,
    input  logic                       Clear,
    output logic                       ClrWe,
    output logic [DMEM_ADDR_WIDTH-1:0] ClrAddr,
    output logic                       Busy,
    output logic                       Halted
);

    // Sequencer states. Encodings 6 and 7 are unused and recover to IDLE.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    // Last address of the clear sweep (all ones).
    localparam logic [DMEM_ADDR_WIDTH-1:0] CNT_LAST = '1;

    logic [2:0]                 state;
    logic [2:0]                 state_nxt;
    logic [PC_WIDTH-1:0]        pc;
    logic [PC_WIDTH-1:0]        pc_nxt;
    logic [INSTR_WIDTH-1:0]     ir;
    logic [INSTR_WIDTH-1:0]     ir_nxt;
    logic [DMEM_ADDR_WIDTH-1:0] clr_cnt;
    logic [DMEM_ADDR_WIDTH-1:0] clr_cnt_nxt;

    // Next-state, PC, IR and sweep-counter logic.
    // Start is only looked at in IDLE and HALT.
    // In ISSUE, Stop takes priority over Clear.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    pc_nxt    = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                ir_nxt    = InstrData;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (Stop) begin
                    state_nxt = S_HALT;
                end else if (Clear) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = S_CLEAR;
                end else begin
                    pc_nxt    = pc + 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_CLEAR: begin
                if (clr_cnt == CNT_LAST) begin
                    clr_cnt_nxt = '0;
                    pc_nxt      = pc + 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers.
    // Reset is synchronous and aborts anything in flight, including a
    // half-finished sweep.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Outputs are taken straight from registers or decoded from the state.
    // The sweep counter rests at zero outside CLEAR, so ClrAddr is zero there.
    assign InstrAddr  = pc;
    assign OpCode     = ir[INSTR_WIDTH-1 -: 3];
    assign Fields     = ir[INSTR_WIDTH-4:0];
    assign IssueValid = (state == S_ISSUE);
    assign ClrWe      = (state == S_CLEAR);
    assign ClrAddr    = clr_cnt;
    assign Busy       = (state == S_FETCH) || (state == S_LOAD) ||
                        (state == S_ISSUE) || (state == S_CLEAR);
    assign Halted     = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer.
// A behavioural model turns each ROM program into the expected per-cycle
// output trace. The outputs are compared on every cycle at the falling edge.
module tb_instr_sequencer;

    localparam int PW = 4;
    localparam int IW = 16;
    localparam int DW = 4;
    localparam int VW = 4 + DW + PW + IW;

    typedef logic [VW-1:0] vec_t;

    logic          clock;
    logic          reset_n;
    logic          Start;
    logic [PW-1:0] InstrAddr;
    logic [IW-1:0] InstrData;
    logic [2:0]    OpCode;
    logic [IW-4:0] Fields;
    logic          IssueValid;
    logic          Stop;
    logic          Clear;
    logic          ClrWe;
    logic [DW-1:0] ClrAddr;
    logic          Busy;
    logic          Halted;

    instr_sequencer #(
        .PC_WIDTH       (PW),
        .INSTR_WIDTH    (IW),
        .DMEM_ADDR_WIDTH(DW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Start     (Start),
        .InstrAddr (InstrAddr),
        .InstrData (InstrData),
        .OpCode    (OpCode),
        .Fields    (Fields),
        .IssueValid(IssueValid),
        .Stop      (Stop),
        .Clear     (Clear),
        .ClrWe     (ClrWe),
        .ClrAddr   (ClrAddr),
        .Busy      (Busy),
        .Halted    (Halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction ROM: the data appears one cycle after the address.
    logic [IW-1:0] rom [0:(1<<PW)-1];
    always @(posedge clock) InstrData <= rom[InstrAddr];

    // Control decoder: 101 = stop, 100 = clear, 111 = both.
    function automatic bit dec_stop(input logic [2:0] op);
        return (op == 3'b101) || (op == 3'b111);
    endfunction
    function automatic bit dec_clear(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b111);
    endfunction
    assign Stop  = dec_stop(OpCode);
    assign Clear = dec_clear(OpCode);

    vec_t obs;
    assign obs = {Busy, Halted, IssueValid, ClrWe, ClrAddr, InstrAddr, OpCode, Fields};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state carried between runs.
    // m_mode: 0 = idle, 1 = halted, 2 = still running.
    int            m_mode;
    logic [PW-1:0] m_pc;
    logic [IW-1:0] m_ir;
    vec_t          exp_q[$];

    function automatic vec_t pk(input bit busy, input bit hlt, input bit iv, input bit we,
                                input logic [DW-1:0] ca, input logic [PW-1:0] addr,
                                input logic [IW-1:0] ir);
        return {busy, hlt, iv, we, ca, addr, ir};
    endfunction

    // Builds the expected trace.
    // Cycle 0 is the IDLE/HALT cycle in which Start is high.
    // After that come fetch, load and issue for each instruction, plus one
    // cycle per word of a clear sweep.
    // The trace ends three cycles into HALT, or at cap cycles if the program
    // has not halted by then.
    function automatic void build(input int cap);
        logic [PW-1:0] pc;
        bit            done;
        logic [2:0]    op;
        exp_q.delete();
        exp_q.push_back(pk(1'b0, m_mode == 1, 1'b0, 1'b0, '0, m_pc, m_ir));
        pc   = '0;
        done = 1'b0;
        while (!done && exp_q.size() < cap) begin
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, '0, pc, m_ir));
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, '0, pc, m_ir));
            m_ir = rom[pc];
            exp_q.push_back(pk(1'b1, 1'b0, 1'b1, 1'b0, '0, pc, m_ir));
            op = m_ir[IW-1 -: 3];
            if (dec_stop(op)) begin
                done = 1'b1;
            end else begin
                if (dec_clear(op))
                    for (int k = 0; k < (1 << DW); k++)
                        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, DW'(k), pc, m_ir));
                pc = pc + 1'b1;
            end
        end
        if (done) begin
            for (int k = 0; k < 3; k++)
                exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 1'b0, '0, pc, m_ir));
            m_mode = 1;
        end else begin
            m_mode = 2;
        end
        m_pc = pc;
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Steps through the first n entries of the expected trace.
    // Start is high in cycle 0. While the model says Busy, Start is
    // driven low (noise 0), randomly (noise 1) or high (noise 2).
    task automatic play(input string name, input int n, input int noise);
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            @(negedge clock);
            check($sformatf("%s_c%0d", name, i), obs, exp_q[i]);
            if (i == 0)
                Start = 1'b1;
            else if (exp_q[i][VW-1])
                Start = (noise == 2) ? 1'b1 : ((noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            else
                Start = 1'b0;
        end
    endtask

    // Holds reset low for two edges. After each edge every output must be zero.
    task automatic do_reset(input string name);
        Start   = 1'b0;
        reset_n = 1'b0;
        for (int e = 0; e < 2; e++) begin
            @(negedge clock);
            check($sformatf("%s_r%0d", name, e), obs, '0);
        end
        reset_n = 1'b1;
        m_mode  = 0;
        m_pc    = '0;
        m_ir    = '0;
    endtask

    initial begin
        int idx;
        Start   = 1'b0;
        reset_n = 1'b0;
        for (int a = 0; a < (1 << PW); a++) rom[a] = '0;
        do_reset("init");

        // Straight-line program 000, 001, 101.
        // Start is held high through every busy cycle, including the ISSUE at address 1.
        for (int a = 0; a < (1 << PW); a++) rom[a] = {3'b001, (IW-3)'($urandom)};
        rom[0] = {3'b000, (IW-3)'($urandom)};
        rom[1] = {3'b001, (IW-3)'($urandom)};
        rom[2] = {3'b101, (IW-3)'($urandom)};
        build(200);
        play("line", exp_q.size(), 2);

        // Clear then stop, restarted from HALT: a 16-word sweep, then fetch at address 1.
        rom[0] = {3'b100, (IW-3)'($urandom)};
        rom[1] = {3'b101, (IW-3)'($urandom)};
        build(200);
        play("clear", exp_q.size(), 0);

        // Reset at the edge that ends the cycle with ClrAddr = 5.
        build(200);
        idx = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx == 0 && exp_q[i][VW-4] && exp_q[i][IW+PW +: DW] == DW'(5)) idx = i;
        play("sweep_rst", idx + 1, 0);
        do_reset("sweep_rst");

        // PC wrap: every opcode is 000, so there is no halt. Reset while running.
        for (int a = 0; a < (1 << PW); a++) rom[a] = {3'b000, (IW-3)'($urandom)};
        build(3 * ((1 << PW) + 4) + 1);
        play("wrap", exp_q.size(), 1);
        do_reset("wrap");

        // Randomized programs with Start toggling while Busy.
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < (1 << PW); a++) rom[a] = IW'($urandom);
            build(150);
            play($sformatf("rnd%0d", t), exp_q.size(), 1);
            if (m_mode == 2) do_reset($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
